// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: requester, scan-timing and memory port bundle for vga_mem_arbiter
interface vga_mem_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW = 16,
  parameter int DW = 16
);
  logic de;
  logic new_frame;
  logic [N_REQ-1:0] req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0] gnt;
  logic mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rdata;
  logic [N_REQ-1:0] rvalid;
  logic [N_REQ-1:0] starve;
  modport master (
    output de, new_frame, req, addr, mem_rdata,
    input gnt, mem_en, mem_addr, rdata, rvalid, starve
  );
  modport slave (
    input de, new_frame, req, addr, mem_rdata,
    output gnt, mem_en, mem_addr, rdata, rvalid, starve
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one sync-read memory port among N_REQ requesters; ARB_BLANK_ONLY_EN limits requesters 1..N_REQ-1 to blanking
module vga_mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 2,
  parameter int MAX_WAIT = 1024
) (
  input logic pix_clk,
  input logic pix_rst,
  vga_mem_arbiter_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0] rr_ptr, rr_idx, gid, mem_id;
  logic [N_REQ-1:0] elig, gnt, starve;
  logic rr_hit, pri, blk, mem_en;
  logic [AW-1:0] mem_addr;
  logic sh_v [RD_LAT];
  logic [PW-1:0] sh_id [RD_LAT];
  logic [15:0] wcnt [N_REQ];
`ifdef ARB_BLANK_ONLY_EN
  assign blk = bus.de;
`else
  assign blk = 1'b0;
`endif
  assign bus.gnt = gnt;
  assign bus.mem_en = mem_en;
  assign bus.mem_addr = mem_addr;
  assign bus.starve = starve;
  assign bus.rdata = bus.mem_rdata[DW-1:0];
  assign bus.rvalid = sh_v[RD_LAT-1] ? N_REQ'(1) << sh_id[RD_LAT-1] : '0;
  // Scan-out fetch wins in the active area; otherwise first eligible requester at or after rr_ptr
  always_comb begin
    elig = bus.req & ~{{(N_REQ-1){blk}}, bus.de};
    pri = bus.de & bus.req[0];
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!rr_hit && elig[(int'(rr_ptr) + k) % N_REQ]) begin
        rr_hit = 1'b1;
        rr_idx = PW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    gid = pri ? '0 : rr_idx;
    gnt = (pix_rst || !(pri || rr_hit)) ? '0 : N_REQ'(1) << gid;
  end
  // Memory command register and round-robin pointer; new_frame re-anchors the pointer at 1
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      mem_en <= 1'b0;
      mem_addr <= '0;
      mem_id <= '0;
      rr_ptr <= PW'(1);
    end else begin
      mem_en <= |gnt;
      if (|gnt) begin
        mem_addr <= bus.addr[int'(gid)*AW +: AW];
        mem_id <= gid;
      end
      if (bus.new_frame)
        rr_ptr <= PW'(1);
      else if (|gnt && !pri)
        rr_ptr <= (int'(rr_idx) == N_REQ-1) ? '0 : rr_idx + 1'b1;
    end
  end
  // Owner tags travel alongside the memory latency so rvalid lines up with mem_rdata
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        sh_v[k] <= 1'b0;
        sh_id[k] <= '0;
      end
    end else begin
      sh_v[0] <= mem_en;
      sh_id[0] <= mem_id;
      for (int k = 1; k < RD_LAT; k++) begin
        sh_v[k] <= sh_v[k-1];
        sh_id[k] <= sh_id[k-1];
      end
    end
  end
  // Saturating wait counters feed sticky starvation flags; the scan-out flag only arms in blanking
  always_ff @(posedge pix_clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (pix_rst) begin
        wcnt[i] <= '0;
        starve[i] <= 1'b0;
      end else begin
        wcnt[i] <= (bus.req[i] && !gnt[i]) ? ((&wcnt[i]) ? wcnt[i] : wcnt[i] + 16'd1) : '0;
        starve[i] <= !bus.new_frame && (starve[i] || (bus.req[i] && !gnt[i] &&
                     ({16'd0, wcnt[i]} + 32'd1 >= 32'(MAX_WAIT)) && (i != 0 || !bus.de)));
      end
    end
  end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed stimulus with scoreboard-checked read returns
module tb_vga_mem_arbiter;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD_LAT = 2;
  localparam int MAX_WAIT = 8;
`ifdef ARB_BLANK_ONLY_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  typedef struct {
    int id;
    logic [DW-1:0] data;
    int at;
  } exp_t;
  logic pix_clk = 1'b0;
  logic pix_rst = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int seq = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] mp [RD_LAT];
  exp_t q[$];
  vga_mem_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus();
  vga_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .pix_clk(pix_clk),
    .pix_rst(pix_rst),
    .bus(bus)
  );
  always #5 pix_clk = ~pix_clk;
  always @(posedge pix_clk) cyc <= cyc + 1;
  // Memory model: data = addr ^ 5A5A, valid RD_LAT cycles after mem_en
  always @(posedge pix_clk) begin
    mp[0] <= bus.mem_en ? (bus.mem_addr ^ 16'h5A5A) : 16'hDEAD;
    for (int k = 1; k < RD_LAT; k++) mp[k] <= mp[k-1];
  end
  assign bus.mem_rdata = mp[RD_LAT-1];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Monitor: pops the scoreboard whenever rvalid shows, flags overdue entries
  always @(negedge pix_clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].at < cyc) begin
      chk("rvalid_missing", 32'(bus.rvalid), 32'(1 << q[0].id));
      void'(q.pop_front());
    end
    if (bus.rvalid != '0) begin
      if (q.size() == 0) chk("rvalid_spurious", 32'(bus.rvalid), 32'd0);
      else begin
        e = q.pop_front();
        chk("rvalid_owner", 32'(bus.rvalid), 32'(1 << e.id));
        chk("rdata", 32'(bus.rdata), 32'(e.data));
        chk("rvalid_cycle", cyc, e.at);
      end
    end
  end
  task automatic step(input logic [N-1:0] r, input logic d, input logic nf, input logic [N-1:0] eg, input string nm);
    int id;
    bus.req = r;
    bus.de = d;
    bus.new_frame = nf;
    for (int i = 0; i < N; i++) bus.addr[i*AW +: AW] = AW'(16'h1000 * (i + 1) + seq);
    seq++;
    #1;
    chk({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
    if (eg != '0) begin
      id = 0;
      for (int i = 0; i < N; i++) if (eg[i]) id = i;
      last_addr = bus.addr[id*AW +: AW];
      q.push_back('{id, last_addr ^ 16'h5A5A, cyc + RD_LAT + 1});
    end
    @(posedge pix_clk);
    #1;
    chk({nm, "_mem_en"}, 32'(bus.mem_en), 32'(eg != '0));
    chk({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'(last_addr));
  endtask
  initial begin
    bus.req = '0;
    bus.de = 1'b0;
    bus.new_frame = 1'b0;
    bus.addr = '0;
    repeat (2) @(posedge pix_clk);
    #1;
    pix_rst = 1'b0;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_starve", 32'(bus.starve), 32'd0);
    for (int k = 0; k < 4; k++) step(4'b1111, 1'b1, 1'b0, 4'b0001, "t1_pri");
    step(4'b1110, 1'b0, 1'b0, 4'b0010, "t2_rr1");
    step(4'b1110, 1'b0, 1'b0, 4'b0100, "t2_rr2");
    step(4'b1110, 1'b0, 1'b0, 4'b1000, "t2_rr3");
    step(4'b1110, 1'b0, 1'b0, 4'b0010, "t2_rr4");
    for (int k = 0; k < 2; k++) begin
      step(4'b0101, 1'b1, 1'b0, 4'b0001, "t3_req0");
      step(4'b0100, 1'b1, 1'b0, BLANK ? 4'b0000 : 4'b0100, "t3_gap");
    end
    step(4'b0100, 1'b0, 1'b0, 4'b0100, "t3_blank");
    chk("t3_no_starve", 32'(bus.starve), 32'd0);
    step(4'b1000, 1'b0, 1'b1, 4'b1000, "t6_nf_grant3");
    step(4'b1111, 1'b0, 1'b0, 4'b0010, "t6_after_nf");
    step(4'b0000, 1'b0, 1'b0, 4'b0000, "t4_idle");
    for (int k = 1; k <= MAX_WAIT; k++) begin
      step(4'b0011, 1'b1, 1'b0, 4'b0001, "t4_wait");
      chk($sformatf("t4_starve_%0d", k), 32'(bus.starve), (k == MAX_WAIT) ? 32'h2 : 32'h0);
    end
    step(4'b0000, 1'b1, 1'b0, 4'b0000, "t4_hold");
    chk("t4_starve_sticky", 32'(bus.starve), 32'h2);
    step(4'b0000, 1'b1, 1'b1, 4'b0000, "t4_nf");
    chk("t4_starve_clear", 32'(bus.starve), 32'h0);
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b1, 1'b0, 4'b0001, "t5_b2b");
    bus.req = '0;
    pix_rst = 1'b1;
    while (q.size() > 0 && q[q.size()-1].at > cyc) void'(q.pop_back());
    @(posedge pix_clk);
    #1;
    pix_rst = 1'b0;
    last_addr = '0;
    chk("t5_mem_en", 32'(bus.mem_en), 32'd0);
    chk("t5_rvalid", 32'(bus.rvalid), 32'd0);
    step(4'b1111, 1'b0, 1'b0, 4'b0010, "t5_rr_ptr");
    for (int k = 0; k < RD_LAT + 3; k++) step(4'b0000, 1'b0, 1'b0, 4'b0000, "drain");
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
